// File: rtl/maxpool_pkg.sv
// Shared types and constants for the 2x2 stride-2 int8 max-pooling stage.
package maxpool_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam int unsigned RowBufDepth = 16;
    localparam int unsigned RowBufAw    = $clog2(RowBufDepth);
    localparam int unsigned PixW        = 8;

    localparam logic [5:0] FlLen4  = 6'd4;
    localparam logic [5:0] FlLen8  = 6'd8;
    localparam logic [5:0] FlLen16 = 6'd16;
    localparam logic [5:0] FlLen32 = 6'd32;

    function automatic logic fl_legal(input logic [5:0] fl);
        return (fl == FlLen4) || (fl == FlLen8) || (fl == FlLen16) || (fl == FlLen32);
    endfunction

endpackage

// File: rtl/maxpool_if.sv
// AXI-Stream bundle used for both the feature input and the pooled output.
interface maxpool_axis_if #(
    parameter int unsigned DataW = 32
);
    logic [DataW-1:0]   TDATA;
    logic [DataW/8-1:0] TKEEP;
    logic               TUSER;
    logic               TLAST;
    logic               TVALID;
    logic               TREADY;

    modport master (output TDATA, output TKEEP, output TUSER, output TLAST, output TVALID,
                    input TREADY);
    modport slave  (input TDATA, input TKEEP, input TUSER, input TLAST, input TVALID,
                    output TREADY);
endinterface

// File: rtl/maxpool_max2.sv
// Signed int8 two-input max; negative results clamp to 0 when MAXPOOL_RELU_EN is defined.
module maxpool_max2 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_max
);

    logic [7:0] w_max;

    assign w_max = ($signed(i_a) > $signed(i_b)) ? i_a : i_b;

`ifdef MAXPOOL_RELU_EN
    assign o_max = w_max[7] ? 8'd0 : w_max;
`else
    assign o_max = w_max;
`endif

endmodule

// File: rtl/maxpool_module.sv
// 2x2 stride-2 max pooling over channel-major int8 feature maps, 4 pixels per stream word.
// Optional ReLU clamp on the pooled bytes is enabled by defining MAXPOOL_RELU_EN.
module maxpool_module
    import maxpool_pkg::*;
#(
    parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    maxpool_axis_if.slave         S_AXIS,
    maxpool_axis_if.master        M_AXIS,
    input  logic                  pool_start,
    output logic                  pool_done,
    input  logic                  pool_done_ack,
    input  logic [8:0]            input_ch,
    input  logic [5:0]            feature_length,
    output logic                  len_err
);

    state_e r_state, w_state_d;

    logic [5:0]  r_fl;
    logic [8:0]  r_nch;
    logic [2:0]  r_col;
    logic [4:0]  r_row;
    logic [7:0]  r_ch;
    logic [7:0]  r_rowbuf [RowBufDepth];
    logic [15:0] r_pack;
    logic        r_pack_half;
    logic [31:0] r_m_data;
    logic        r_m_valid;
    logic        r_m_last;
    logic        r_done;
    logic        r_len_err;

    logic [C_S00_AXIS_TDATA_WIDTH-1:0] w_word;
    logic [7:0]          w_h0, w_h1, w_v0, w_v1;
    logic [RowBufAw-1:0] w_idx0, w_idx1;
    logic w_cfg_ok, w_start_ok, w_start_bad;
    logic w_s_ready, w_accept, w_m_fire, w_load;
    logic w_col_last, w_row_last, w_ch_last, w_in_last;
    logic w_unused_side;

    assign w_word        = S_AXIS.TDATA;
    assign w_unused_side = ^{S_AXIS.TKEEP, S_AXIS.TUSER};

    // A zero or oversized channel count is rejected like an illegal side length.
    assign w_cfg_ok    = fl_legal(feature_length) && (input_ch != 9'd0) && (input_ch <= 9'd256);
    assign w_start_ok  = (r_state == StIdle) && pool_start && w_cfg_ok;
    assign w_start_bad = (r_state == StIdle) && pool_start && !w_cfg_ok;

    assign w_s_ready = (r_state == StRun) && (!r_m_valid || M_AXIS.TREADY);
    assign w_accept  = w_s_ready && S_AXIS.TVALID;
    assign w_m_fire  = r_m_valid && M_AXIS.TREADY;

    assign w_col_last = ({1'b0, r_col} == (r_fl[5:2] - 4'd1));
    assign w_row_last = ({1'b0, r_row} == (r_fl - 6'd1));
    assign w_ch_last  = ({1'b0, r_ch} == (r_nch - 9'd1));
    assign w_in_last  = w_col_last && w_row_last && w_ch_last;

    assign w_idx0 = {r_col, 1'b0};
    assign w_idx1 = {r_col, 1'b1};

    // Odd-row word completing a packed output word.
    assign w_load = w_accept && r_row[0] && r_pack_half;

    maxpool_max2 u_hmax0 (.i_a(w_word[7:0]),       .i_b(w_word[15:8]),  .o_max(w_h0));
    maxpool_max2 u_hmax1 (.i_a(w_word[23:16]),     .i_b(w_word[31:24]), .o_max(w_h1));
    maxpool_max2 u_vmax0 (.i_a(r_rowbuf[w_idx0]),  .i_b(w_h0),          .o_max(w_v0));
    maxpool_max2 u_vmax1 (.i_a(r_rowbuf[w_idx1]),  .i_b(w_h1),          .o_max(w_v1));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_start_ok) w_state_d = StRun;
            StRun:   if (w_accept && w_in_last) w_state_d = StDrain;
            StDrain: if (w_m_fire && r_m_last) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fl  <= '0;
            r_nch <= '0;
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
        end else if (w_start_ok) begin
            r_fl  <= feature_length;
            r_nch <= input_ch;
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                if (w_row_last) begin
                    r_row <= '0;
                    r_ch  <= w_ch_last ? 8'd0 : r_ch + 8'd1;
                end else begin
                    r_row <= r_row + 5'd1;
                end
            end else begin
                r_col <= r_col + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < RowBufDepth; i++) begin
                r_rowbuf[i] <= '0;
            end
        end else if (w_accept && !r_row[0]) begin
            r_rowbuf[w_idx0] <= w_h0;
            r_rowbuf[w_idx1] <= w_h1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pack      <= '0;
            r_pack_half <= 1'b0;
        end else if (w_start_ok) begin
            r_pack_half <= 1'b0;
        end else if (w_accept && r_row[0]) begin
            if (r_pack_half) begin
                r_pack_half <= 1'b0;
            end else begin
                r_pack      <= {w_v1, w_v0};
                r_pack_half <= 1'b1;
            end
        end
    end

    // Loading is only possible when the output register is empty or firing this cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_load) begin
            r_m_data  <= {w_v1, w_v0, r_pack};
            r_m_valid <= 1'b1;
            r_m_last  <= w_in_last;
        end else if (w_m_fire) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            if (pool_done_ack) begin
                r_done <= 1'b0;
            end else if (w_m_fire && r_m_last) begin
                r_done <= 1'b1;
            end

            if (w_start_bad) begin
                r_len_err <= 1'b1;
            end else if (w_start_ok) begin
                r_len_err <= 1'b0;
            end else if (w_accept && (S_AXIS.TLAST != w_in_last)) begin
                r_len_err <= 1'b1;
            end
        end
    end

    assign S_AXIS.TREADY = w_s_ready;
    assign M_AXIS.TDATA  = r_m_data;
    assign M_AXIS.TKEEP  = 4'hF;
    assign M_AXIS.TUSER  = 1'b0;
    assign M_AXIS.TLAST  = r_m_last;
    assign M_AXIS.TVALID = r_m_valid;
    assign pool_done     = r_done;
    assign len_err       = r_len_err;

endmodule

// File: tb/tb_maxpool_module.sv
// Directed bench for maxpool_module with a window-level reference model and stream scoreboard.
module tb_maxpool_module;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       pool_start, pool_done, pool_done_ack, len_err;
    logic [8:0] input_ch;
    logic [5:0] feature_length;

    always #5 clk = ~clk;

    maxpool_axis_if s_if ();
    maxpool_axis_if m_if ();

    maxpool_module #(.C_S00_AXIS_TDATA_WIDTH(32)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .S_AXIS         (s_if),
        .M_AXIS         (m_if),
        .pool_start     (pool_start),
        .pool_done      (pool_done),
        .pool_done_ack  (pool_done_ack),
        .input_ch       (input_ch),
        .feature_length (feature_length),
        .len_err        (len_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_out  = 0;
    bit rand_rdy = 1'b0;

    logic [31:0] in_w [$];
    logic [32:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: max over each 2x2 window of the image, bytes packed in emission order.
    function automatic void model(input int fl, input int ch);
        logic [7:0]        bytes [$];
        logic [31:0]       w;
        logic signed [7:0] m, p;
        int                wpr, idx;
        wpr = fl / 4;
        for (int c = 0; c < ch; c++) begin
            for (int r = 0; r < fl; r += 2) begin
                for (int x = 0; x < fl; x += 2) begin
                    m = -8'sd128;
                    for (int dy = 0; dy < 2; dy++) begin
                        for (int dx = 0; dx < 2; dx++) begin
                            idx = c * fl * wpr + (r + dy) * wpr + (x + dx) / 4;
                            w = in_w[idx];
                            p = w[8*((x + dx) % 4) +: 8];
                            if (p > m) m = p;
                        end
                    end
`ifdef MAXPOOL_RELU_EN
                    if (m < 0) m = 8'sd0;
`endif
                    bytes.push_back(m);
                end
            end
        end
        for (int k = 0; k < bytes.size(); k += 4) begin
            exp_q.push_back({(k + 4 == bytes.size()), bytes[k+3], bytes[k+2], bytes[k+1],
                             bytes[k]});
        end
    endfunction

    logic [31:0] held_data;
    logic        held;

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rstn) begin
            held <= 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", m_if.TVALID, 1'b1);
                check("hold_data", m_if.TDATA, held_data);
            end
            if (m_if.TVALID && m_if.TREADY) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h, expected no word", m_if.TDATA);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_if.TDATA, e[31:0]);
                    check("out_last", m_if.TLAST, e[32]);
                end
                n_out++;
            end
            held      <= m_if.TVALID && !m_if.TREADY;
            held_data <= m_if.TDATA;
        end
    end

    initial begin
        m_if.TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_if.TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int fl, input int ch);
        feature_length = 6'(fl);
        input_ch       = 9'(ch);
        pool_start     = 1'b1;
        tick();
        pool_start     = 1'b0;
    endtask

    task automatic send(input int n, input int tlast_idx);
        int guard;
        for (int i = 0; i < n; i++) begin
            s_if.TDATA  = in_w[i];
            s_if.TLAST  = (i == tlast_idx);
            s_if.TVALID = 1'b1;
            guard = 0;
            @(negedge clk);
            while (!s_if.TREADY && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 2000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: word %0d not accepted, expected accept", i);
                s_if.TVALID = 1'b0;
                return;
            end
            tick();
        end
        s_if.TVALID = 1'b0;
        s_if.TLAST  = 1'b0;
    endtask

    task automatic wait_outs(input int target);
        int guard = 0;
        while (n_out < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (n_out < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL out_timeout: got %0d words, expected %0d", n_out, target);
        end
        tick();
    endtask

    task automatic load_s1();
        in_w.delete();
        in_w.push_back(32'h04030201);
        in_w.push_back(32'h08070605);
        in_w.push_back(32'h0C0B0A09);
        in_w.push_back(32'h100F0E0D);
    endtask

    initial begin
        logic [32:0] pin;
        int base, rdy_cnt;
        s_if.TDATA = '0; s_if.TKEEP = 4'hF; s_if.TUSER = 1'b0;
        s_if.TLAST = 1'b0; s_if.TVALID = 1'b0;
        pool_start = 1'b0; pool_done_ack = 1'b0;
        input_ch = 9'd1; feature_length = 6'd4;

        repeat (3) tick();
        check("rst_s_tready", s_if.TREADY, 1'b0);
        check("rst_m_tvalid", m_if.TVALID, 1'b0);
        check("rst_m_tlast", m_if.TLAST, 1'b0);
        check("rst_m_tdata", m_if.TDATA, 32'h0);
        check("rst_done", pool_done, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        check("m_tkeep", m_if.TKEEP, 4'hF);
        check("m_tuser", m_if.TUSER, 1'b0);
        rstn = 1'b1;
        tick();

        // Ascending 4x4 single channel.
        load_s1();
        model(4, 1);
        pin = exp_q[0];
        check("model_pin_s1", pin[31:0], 32'h100E0806);
        check("model_pin_s1_last", pin[32], 1'b1);
        base = n_out;
        start(4, 1);
        send(4, 3);
        wait_outs(base + 1);
        check("s1_done", pool_done, 1'b1);
        check("s1_len_err", len_err, 1'b0);
        check("s1_idle_tready", s_if.TREADY, 1'b0);
        pool_done_ack = 1'b1;
        tick();
        pool_done_ack = 1'b0;
        check("s1_ack_clears", pool_done, 1'b0);

        // -128 against -1 in every window, with ack held to test its priority.
        in_w.delete();
        in_w.push_back(32'hFF80FF80);
        in_w.push_back(32'hFFFFFFFF);
        in_w.push_back(32'h80FF80FF);
        in_w.push_back(32'hFFFFFFFF);
        model(4, 1);
        pin = exp_q[0];
`ifdef MAXPOOL_RELU_EN
        check("model_pin_s2", pin[31:0], 32'h00000000);
`else
        check("model_pin_s2", pin[31:0], 32'hFFFFFFFF);
`endif
        pool_done_ack = 1'b1;
        base = n_out;
        start(4, 1);
        send(4, 3);
        wait_outs(base + 1);
        check("s2_ack_priority", pool_done, 1'b0);
        pool_done_ack = 1'b0;

        // Illegal side length.
        start(12, 1);
        check("s3_len_err", len_err, 1'b1);
        s_if.TVALID = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (s_if.TREADY) rdy_cnt++;
        end
        tick();
        s_if.TVALID = 1'b0;
        check("s3_no_tready", rdy_cnt, 0);
        check("s3_no_out", n_out, base + 1);

        // Early TLAST on word 10 of 32.
        in_w.delete();
        for (int i = 0; i < 32; i++) in_w.push_back($urandom);
        model(8, 2);
        check("model_cnt_s4", exp_q.size(), 8);
        base = n_out;
        start(8, 2);
        check("s4_len_err_cleared", len_err, 1'b0);
        send(32, 10);
        wait_outs(base + 8);
        check("s4_len_err", len_err, 1'b1);
        check("s4_out_cnt", n_out - base, 8);
        check("s4_done", pool_done, 1'b1);
        pool_done_ack = 1'b1;
        tick();
        pool_done_ack = 1'b0;

        // Large random run with output backpressure.
        in_w.delete();
        for (int i = 0; i < 768; i++) in_w.push_back($urandom);
        model(32, 3);
        check("model_cnt_s5", exp_q.size(), 192);
        rand_rdy = 1'b1;
        base = n_out;
        start(32, 3);
        send(768, 767);
        wait_outs(base + 192);
        rand_rdy = 1'b0;
        tick();
        check("s5_out_cnt", n_out - base, 192);
        check("s5_len_err", len_err, 1'b0);
        check("s5_done", pool_done, 1'b1);
        check("s5_queue_empty", exp_q.size(), 0);

        // Reset mid-operation discards partial work.
        in_w.delete();
        for (int i = 0; i < 64; i++) in_w.push_back($urandom);
        base = n_out;
        start(16, 1);
        send(5, -1);
        rstn = 1'b0;
        #1;
        check("s6_rst_tvalid", m_if.TVALID, 1'b0);
        check("s6_rst_tdata", m_if.TDATA, 32'h0);
        check("s6_rst_tready", s_if.TREADY, 1'b0);
        check("s6_rst_done", pool_done, 1'b0);
        check("s6_rst_len_err", len_err, 1'b0);
        repeat (2) tick();
        rstn = 1'b1;
        repeat (10) tick();
        check("s6_no_out", n_out, base);
        load_s1();
        model(4, 1);
        start(4, 1);
        send(4, 3);
        wait_outs(base + 1);
        check("s6_done", pool_done, 1'b1);
        check("s6_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
